// File: rtl/pong_pkg.sv
// Shared state encoding, default geometry and speed helpers for the pong ball.
package pong_pkg;

    typedef enum logic [1:0] {IDLE, RUN, SCORED} state_t;

    localparam int POS_W = 10;
    localparam int SPD_W = 4;

    localparam int DEF_H_RES       = 640;
    localparam int DEF_V_RES       = 480;
    localparam int DEF_BALL_SIZE   = 8;
    localparam int DEF_PAD_H       = 64;
    localparam int DEF_PAD_W       = 8;
    localparam int DEF_PAD_XL      = 16;
    localparam int DEF_PAD_XR      = 616;
    localparam int DEF_SPD_INIT    = 1;
    localparam int DEF_SPD_MAX     = 6;
    localparam int DEF_HOLD_FRAMES = 60;

    function automatic logic [SPD_W-1:0] spd_inc(input logic [SPD_W-1:0] s, input int smax);
        return (int'(s) >= smax) ? s : s + 1'b1;
    endfunction

endpackage

// File: rtl/pong_ball_axis.sv
// One axis of ball motion: step by speed in the signed direction, clamping at 0 and MAX_POS.
module pong_ball_axis
    import pong_pkg::*;
#(
    parameter int MAX_POS = 472
) (
    input  logic [POS_W-1:0] pos,
    input  logic             neg,
    input  logic [SPD_W-1:0] spd,
    output logic [POS_W-1:0] nxt,
    output logic             at_lo,
    output logic             at_hi
);

    logic [POS_W:0] fwd;
    logic [POS_W:0] spd_x;

    // One extra bit keeps pos+spd from wrapping near the far edge.
    always_comb begin
        spd_x = (POS_W+1)'(spd);
        fwd   = {1'b0, pos} + spd_x;
        at_lo = neg && ({1'b0, pos} <= spd_x);
        at_hi = !neg && (fwd >= (POS_W+1)'(MAX_POS));
        if (at_lo)
            nxt = '0;
        else if (at_hi)
            nxt = POS_W'(MAX_POS);
        else if (neg)
            nxt = pos - POS_W'(spd);
        else
            nxt = fwd[POS_W-1:0];
    end

endmodule

// File: rtl/pong_ball.sv
// Ball FSM: serve, per-frame motion with wall/paddle reflection, goal detection and post-goal hold.
module pong_ball
    import pong_pkg::*;
#(
    parameter int H_RES       = DEF_H_RES,
    parameter int V_RES       = DEF_V_RES,
    parameter int BALL_SIZE   = DEF_BALL_SIZE,
    parameter int PAD_H       = DEF_PAD_H,
    parameter int PAD_W       = DEF_PAD_W,
    parameter int PAD_XL      = DEF_PAD_XL,
    parameter int PAD_XR      = DEF_PAD_XR,
    parameter int SPD_INIT    = DEF_SPD_INIT,
    parameter int SPD_MAX     = DEF_SPD_MAX,
    parameter int HOLD_FRAMES = DEF_HOLD_FRAMES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick,
    input  logic             serve,
    input  logic [POS_W-1:0] lpad_y,
    input  logic [POS_W-1:0] rpad_y,
    output logic [POS_W-1:0] ballx,
    output logic [POS_W-1:0] bally,
    output logic             hit,
    output logic             score_l,
    output logic             score_r,
    output logic             running
);

    localparam int CX     = (H_RES - BALL_SIZE) / 2;
    localparam int CY     = (V_RES - BALL_SIZE) / 2;
    localparam int LPLANE = PAD_XL + PAD_W;
    localparam int RPLANE = PAD_XR - BALL_SIZE;
    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

    state_t             state;
    logic [SPD_W-1:0]   spd;
    logic               dx_neg, dy_neg;
    logic [HOLD_W-1:0]  hold_cnt;

    logic [POS_W-1:0]   x_nxt, y_nxt;
    logic               x_lo, x_hi, y_lo, y_hi;
    logic [POS_W:0]     bx, by, spd_x;
    logic               l_ovl, r_ovl, lhit, rhit;

    pong_ball_axis #(.MAX_POS(H_RES - BALL_SIZE)) u_x (
        .pos(ballx), .neg(dx_neg), .spd(spd), .nxt(x_nxt), .at_lo(x_lo), .at_hi(x_hi)
    );

    pong_ball_axis #(.MAX_POS(V_RES - BALL_SIZE)) u_y (
        .pos(bally), .neg(dy_neg), .spd(spd), .nxt(y_nxt), .at_lo(y_lo), .at_hi(y_hi)
    );

    // Paddle contact: the step would reach or cross the contact plane from the court side,
    // and the ball's rows overlap the paddle's rows.
    always_comb begin
        bx    = {1'b0, ballx};
        by    = {1'b0, bally};
        spd_x = (POS_W+1)'(spd);
        l_ovl = (by + (POS_W+1)'(BALL_SIZE) > {1'b0, lpad_y}) &&
                (by < {1'b0, lpad_y} + (POS_W+1)'(PAD_H));
        r_ovl = (by + (POS_W+1)'(BALL_SIZE) > {1'b0, rpad_y}) &&
                (by < {1'b0, rpad_y} + (POS_W+1)'(PAD_H));
        lhit  = dx_neg && (bx <= (POS_W+1)'(LPLANE) + spd_x) &&
                (bx >= (POS_W+1)'(LPLANE)) && l_ovl;
        rhit  = !dx_neg && (bx + spd_x >= (POS_W+1)'(RPLANE)) &&
                (bx <= (POS_W+1)'(RPLANE)) && r_ovl;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ballx    <= POS_W'(CX);
            bally    <= POS_W'(CY);
            spd      <= SPD_W'(SPD_INIT);
            dx_neg   <= 1'b0;
            dy_neg   <= 1'b0;
            hold_cnt <= '0;
            hit      <= 1'b0;
            score_l  <= 1'b0;
            score_r  <= 1'b0;
            running  <= 1'b0;
        end else begin
            hit     <= 1'b0;
            score_l <= 1'b0;
            score_r <= 1'b0;
            case (state)
                IDLE: if (serve) begin
                    state   <= RUN;
                    running <= 1'b1;
                end
                RUN: if (frame_tick) begin
                    bally <= y_nxt;
                    if (y_lo)
                        dy_neg <= 1'b0;
                    else if (y_hi)
                        dy_neg <= 1'b1;
                    if (lhit) begin
                        ballx  <= POS_W'(LPLANE);
                        dx_neg <= 1'b0;
                        hit    <= 1'b1;
                        spd    <= spd_inc(spd, SPD_MAX);
                    end else if (rhit) begin
                        ballx  <= POS_W'(RPLANE);
                        dx_neg <= 1'b1;
                        hit    <= 1'b1;
                        spd    <= spd_inc(spd, SPD_MAX);
                    end else begin
                        ballx <= x_nxt;
                        if (x_lo || x_hi) begin
                            state   <= SCORED;
                            running <= 1'b0;
                            score_r <= x_lo;
                            score_l <= x_hi;
                            // Next serve heads toward the side that conceded.
                            dx_neg  <= x_lo;
                        end
                    end
                end
                SCORED: if (frame_tick) begin
                    if (hold_cnt == HOLD_W'(HOLD_FRAMES - 1)) begin
                        hold_cnt <= '0;
                        state    <= IDLE;
                        ballx    <= POS_W'(CX);
                        bally    <= POS_W'(CY);
                        spd      <= SPD_W'(SPD_INIT);
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pong_ball.sv
// Directed play-through of pong_ball with hand-traced ball trajectories.
module tb_pong_ball;

    logic       clk = 1'b0;
    logic       rst, frame_tick, serve;
    logic [9:0] lpad_y, rpad_y, ballx, bally;
    logic       hit, score_l, score_r, running;

    int n_chk  = 0;
    int n_pass = 0;

    pong_ball dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .serve(serve),
        .lpad_y(lpad_y), .rpad_y(rpad_y), .ballx(ballx), .bally(bally),
        .hit(hit), .score_l(score_l), .score_r(score_r), .running(running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic pos(input string tag, input int x, input int y);
        chk({tag, ".x"}, int'(ballx), x);
        chk({tag, ".y"}, int'(bally), y);
    endtask

    task automatic tick();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_serve();
        @(negedge clk) serve = 1'b1;
        @(negedge clk) serve = 1'b0;
    endtask

    // Paddles follow the ball so every paddle approach is a hit.
    task automatic track();
        lpad_y = (bally >= 10'd20) ? bally - 10'd20 : 10'd0;
        rpad_y = lpad_y;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int hits, ticks, x0, d, any_score, found;
        bit meas;
        int prev;

        rst = 1'b1; frame_tick = 1'b0; serve = 1'b0;
        lpad_y = 10'd150; rpad_y = 10'd400;
        repeat (3) @(negedge clk);
        pos("rst", 316, 236);
        chk("rst.running", int'(running), 0);
        chk("rst.hit", int'(hit), 0);
        rst = 1'b0;

        tick();
        pos("idle_tick", 316, 236);
        chk("idle_tick.running", int'(running), 0);

        do_serve();
        chk("serve.running", int'(running), 1);
        tick();
        pos("first", 317, 237);

        run(235);
        pos("bottom", 552, 472);
        run(55);
        pos("pre_rhit1", 607, 417);
        tick();
        pos("rhit1", 608, 416);
        chk("rhit1.hit", int'(hit), 1);

        run(208);
        pos("top_eq", 192, 0);
        chk("top_eq.hit", int'(hit), 0);
        run(83);
        pos("pre_lhit", 26, 166);
        tick();
        pos("lhit", 24, 168);
        chk("lhit.hit", int'(hit), 1);
        tick();
        pos("lhit_spd3", 27, 171);
        chk("lhit_spd3.hit", int'(hit), 0);

        run(101);
        pos("bot_clamp", 330, 472);
        rpad_y = 10'd160;
        run(92);
        pos("pre_rhit2", 606, 196);
        tick();
        pos("rhit2", 608, 193);
        chk("rhit2.hit", int'(hit), 1);

        lpad_y = 10'd0;
        run(48);
        pos("pre_top", 416, 1);
        tick();
        pos("top_clamp", 412, 0);
        chk("top_clamp.score_r", int'(score_r), 0);
        chk("top_clamp.running", int'(running), 1);

        run(102);
        pos("pre_goal", 4, 408);
        tick();
        pos("goal", 0, 412);
        chk("goal.score_r", int'(score_r), 1);
        chk("goal.score_l", int'(score_l), 0);
        chk("goal.running", int'(running), 0);
        chk("goal.hit", int'(hit), 0);

        run(59);
        pos("hold59", 0, 412);
        chk("hold59.score_r", int'(score_r), 0);
        do_serve();
        chk("scored_serve.running", int'(running), 0);
        tick();
        pos("hold60", 316, 236);
        chk("hold60.running", int'(running), 0);

        do_serve();
        chk("reserve.running", int'(running), 1);
        tick();
        pos("reserve", 315, 237);

        hits = 0; ticks = 0; meas = 0; any_score = 0; x0 = 0;
        while ((hits < 10 || meas) && ticks < 4000) begin
            track();
            tick();
            ticks++;
            if (score_l || score_r) any_score = 1;
            if (meas) begin
                d = (int'(ballx) > x0) ? int'(ballx) - x0 : x0 - int'(ballx);
                if (hits == 1)  chk("spd_after_hit1", d, 2);
                if (hits == 5)  chk("spd_after_hit5", d, 6);
                if (hits == 10) chk("spd_after_hit10", d, 6);
                meas = 0;
            end
            if (hit) begin
                hits++;
                x0 = int'(ballx);
                meas = 1;
            end
        end
        chk("sat.hits", hits, 10);
        chk("sat.no_score", any_score, 0);

        found = 0; prev = int'(ballx);
        for (int i = 0; i < 400 && found == 0; i++) begin
            track();
            tick();
            if (int'(ballx) < prev && ballx >= 10'd24 && ballx <= 10'd30) found = 1;
            prev = int'(ballx);
        end
        chk("pre_rst.found", found, 1);
        track();
        @(negedge clk) begin rst = 1'b1; frame_tick = 1'b1; end
        @(negedge clk) begin rst = 1'b0; frame_tick = 1'b0; end
        pos("midrst", 316, 236);
        chk("midrst.hit", int'(hit), 0);
        chk("midrst.score_r", int'(score_r), 0);
        chk("midrst.score_l", int'(score_l), 0);
        chk("midrst.running", int'(running), 0);

        do_serve();
        tick();
        pos("post_rst", 317, 237);
        chk("post_rst.running", int'(running), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
